game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//   Game-state controller and pixel compositor for the dinosaur runner. Sits directly
//   downstream of the obstacle and dino sprite stages. Merges their 1-bit pixel outputs
//   into one video pixel and detects sprite overlap (collision).
//   Drives game_status, speed and score back to the sprite stages and the score display.
// PARAMETERS
//   SPEED_INIT   4'd2     speed loaded on every game start (px/frame)
//   SPEED_MAX    4'd12    speed ceiling; no further increments once reached
//   FRAMES_STEP  10'd600  frames per speed increment (~10 s at 60 Hz)
//   H_VIS        10'd640  visible columns; pixels with col_addr>=H_VIS are ignored
//   V_VIS        9'd480   visible rows; pixels with row_addr>=V_VIS are ignored
// PORTS
//   clkdiv       in   1   pixel clock; all logic on posedge
//   RESET        in   1   asynchronous, active-high reset
//   START        in   1   start/restart button; synchronous to clkdiv, level
//   fresh        in   1   frame strobe from VGA timing; falling edge = end of frame
//   row_addr     in   9   current scan row (same cycle as sprite px inputs)
//   col_addr     in   10  current scan column
//   cactus_px    in   1   obstacle sprite pixel, registered by its stage
//   dino_px      in   1   dino sprite pixel, registered by its stage
//   game_status  out  1   1 = RUN state, else 0
//   speed        out  4   current scroll speed
//   score        out  16  4-digit BCD score, current game
//   hi_score     out  16  4-digit BCD best score since RESET
//   collided     out  1   1 while in OVER state
//   pix_out      out  1   composited pixel = cactus_px | dino_px, visible area only
// BEHAVIOUR
//   Reset: state=IDLE, game_status=0, speed=SPEED_INIT, score=0, hi_score=0,
//     collided=0, pix_out=0, hit=0, frame_cnt=0, start_d=0, fresh_d=1.
//   Edge detect: start_rise = START & ~start_d; frame_end = fresh_d & ~fresh.
//     start_d and fresh_d are registered every cycle.
//   FSM (2-bit):
//     IDLE(00): start_rise -> RUN. On entry to RUN: score=0, speed=SPEED_INIT,
//       frame_cnt=0, hit=0.
//     RUN(01): each cycle, if row_addr<V_VIS && col_addr<H_VIS && cactus_px && dino_px,
//       set sticky hit. On frame_end:
//       - if hit (including an overlap on that same cycle): -> OVER.
//       - else score += 1 (BCD, per-digit carry at 9). Score saturates at 9999, no wrap.
//       - frame_cnt += 1. When frame_cnt==FRAMES_STEP-1: frame_cnt=0 and
//         speed = min(speed+1, SPEED_MAX).
//     OVER(10): collided=1. Score frozen.
//       On the entry cycle, hi_score = max(hi_score, score), compared as BCD.
//       start_rise -> RUN, same entry actions as from IDLE.
//     11: illegal; next state IDLE.
//   Same-cycle events: start_rise and frame_end together in IDLE/OVER -> enter RUN.
//     That frame_end does not count. In RUN, START is ignored.
//   Hit clears on RUN entry, so overlap from a previous frame never ends a new game.
//   Outputs game_status, collided, speed, score, hi_score are registered.
//     They change 1 cycle after the causing edge.
//   pix_out: registered, 1-cycle latency from the sprite px inputs. Forced 0 outside the
//     visible area. In OVER, pix_out = ~(cactus_px|dino_px) inside the visible area
//     (inverted screen).
//   RESET mid-game: immediate return to reset values; hi_score is lost.
// TESTING
//   1 RESET, then pulse START 1 cycle -> game_status=1 next cycle, score=0000, speed=2.
//   2 RUN, 60 fresh falling edges, no overlap -> score=16'h0060, still RUN.
//   3 RUN, drive cactus_px=dino_px=1 at row 350 col 100 for 1 cycle, then frame_end ->
//     state OVER, collided=1, game_status=0, hi_score=score.
//   4 Same overlap at col 700 (invisible) -> no collision, score increments.
//   5 FRAMES_STEP=4: 44 frames -> speed clamps at 12 and holds.
//     Preload score 9998, 3 frames -> score=9999.
//   6 In OVER, raise START on the same cycle as frame_end -> RUN, score=0, hit=0.
//     Assert RESET mid-RUN -> all outputs at reset values.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: dino-runner game FSM, BCD score keeping and sprite pixel compositor.
// Collision is a sticky overlap of visible cactus and dino pixels, resolved at end of frame.
module game_ctrl #(
    parameter logic [3:0] SPEED_INIT  = 4'd2,
    parameter logic [3:0] SPEED_MAX   = 4'd12,
    parameter logic [9:0] FRAMES_STEP = 10'd600,
    parameter logic [9:0] H_VIS       = 10'd640,
    parameter logic [8:0] V_VIS       = 9'd480
) (
    input  logic        clkdiv,
    input  logic        RESET,
    input  logic        START,
    input  logic        fresh,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        cactus_px,
    input  logic        dino_px,
    output logic        game_status,
    output logic [3:0]  speed,
    output logic [15:0] score,
    output logic [15:0] hi_score,
    output logic        collided,
    output logic        pix_out
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, OVER = 2'b10} state_t;

    state_t      state_q;
    logic        start_q, fresh_q, hit_q, game_status_q, collided_q, pix_q, pix_d;
    logic [3:0]  speed_q, speed_d;
    logic [9:0]  frame_cnt_q;
    logic [15:0] score_q, score_d, hi_score_q;
    logic        start_rise, frame_end, visible, overlap, step_last;

    // Per-digit BCD increment that saturates at 9999 instead of wrapping.
    function automatic logic [15:0] bcd_inc(input logic [15:0] s);
        logic [15:0] r;
        logic        c;
        r = s;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                r[4*i +: 4] = (s[4*i +: 4] == 4'd9) ? 4'd0 : s[4*i +: 4] + 4'd1;
                c = (s[4*i +: 4] == 4'd9);
            end
        end
        return (s == 16'h9999) ? s : r;
    endfunction

    assign start_rise = START & ~start_q;
    assign frame_end  = fresh_q & ~fresh;
    assign visible    = (row_addr < V_VIS) && (col_addr < H_VIS);
    assign overlap    = visible & cactus_px & dino_px;
    assign step_last  = frame_cnt_q == FRAMES_STEP - 10'd1;

    always_comb begin
        score_d = bcd_inc(score_q);
        speed_d = (speed_q >= SPEED_MAX) ? SPEED_MAX : speed_q + 4'd1;
        pix_d   = visible ? ((state_q == OVER) ^ (cactus_px | dino_px)) : 1'b0;
    end

    always_ff @(posedge clkdiv or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            fresh_q       <= 1'b1;
            hit_q         <= 1'b0;
            game_status_q <= 1'b0;
            collided_q    <= 1'b0;
            pix_q         <= 1'b0;
            speed_q       <= SPEED_INIT;
            frame_cnt_q   <= '0;
            score_q       <= '0;
            hi_score_q    <= '0;
        end else begin
            start_q <= START;
            fresh_q <= fresh;
            pix_q   <= pix_d;
            case (state_q)
                IDLE, OVER: if (start_rise) begin
                    state_q       <= RUN;
                    game_status_q <= 1'b1;
                    collided_q    <= 1'b0;
                    score_q       <= '0;
                    speed_q       <= SPEED_INIT;
                    frame_cnt_q   <= '0;
                    hit_q         <= 1'b0;
                end
                RUN: begin
                    hit_q <= hit_q | overlap;
                    if (frame_end) begin
                        frame_cnt_q <= step_last ? 10'd0 : frame_cnt_q + 10'd1;
                        if (step_last) speed_q <= speed_d;
                        if (hit_q | overlap) begin
                            state_q       <= OVER;
                            game_status_q <= 1'b0;
                            collided_q    <= 1'b1;
                            hi_score_q    <= (score_q > hi_score_q) ? score_q : hi_score_q;
                        end else begin
                            score_q <= score_d;
                        end
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    game_status_q <= 1'b0;
                    collided_q    <= 1'b0;
                end
            endcase
        end
    end

    assign game_status = game_status_q;
    assign speed       = speed_q;
    assign score       = score_q;
    assign hi_score    = hi_score_q;
    assign collided    = collided_q;
    assign pix_out     = pix_q;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed + randomized bench for game_ctrl against an integer-level game model.
module tb_game_ctrl;
    localparam int FS = 4;

    logic        clkdiv = 1'b0, RESET = 1'b1, START = 1'b0, fresh = 1'b1;
    logic [8:0]  row_addr = '0;
    logic [9:0]  col_addr = '0;
    logic        cactus_px = 1'b0, dino_px = 1'b0;
    logic        game_status, collided, pix_out;
    logic [3:0]  speed;
    logic [15:0] score, hi_score;

    int passed = 0, total = 0;

    int m_score, m_hi, m_speed, m_frames;
    bit m_run, m_over, m_hit, m_start_prev, m_fresh_prev, m_pix;

    game_ctrl #(.FRAMES_STEP(10'd4)) dut (
        .clkdiv(clkdiv), .RESET(RESET), .START(START), .fresh(fresh),
        .row_addr(row_addr), .col_addr(col_addr), .cactus_px(cactus_px), .dino_px(dino_px),
        .game_status(game_status), .speed(speed), .score(score), .hi_score(hi_score),
        .collided(collided), .pix_out(pix_out)
    );

    always #5 clkdiv = ~clkdiv;

    function automatic logic [15:0] to_bcd(input int v);
        return 16'(((v / 1000) % 10) << 12 | ((v / 100) % 10) << 8 | ((v / 10) % 10) << 4 | (v % 10));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_run = 0; m_over = 0; m_hit = 0; m_score = 0; m_hi = 0; m_speed = 2;
        m_frames = 0; m_start_prev = 0; m_fresh_prev = 1; m_pix = 0;
    endtask

    task automatic model_step();
        bit sr, fe, vis, ov, any;
        sr  = START && !m_start_prev;
        fe  = m_fresh_prev && !fresh;
        vis = row_addr < 480 && col_addr < 640;
        any = cactus_px || dino_px;
        ov  = vis && cactus_px && dino_px;
        m_pix = vis && (m_over ? !any : any);
        if (!m_run) begin
            if (sr) begin
                m_run = 1; m_over = 0; m_hit = 0; m_score = 0; m_speed = 2; m_frames = 0;
            end
        end else begin
            m_hit = m_hit || ov;
            if (fe) begin
                m_frames++;
                if (m_frames == FS) begin
                    m_frames = 0;
                    m_speed = (m_speed + 1 > 12) ? 12 : m_speed + 1;
                end
                if (m_hit) begin
                    m_run = 0; m_over = 1;
                    if (m_score > m_hi) m_hi = m_score;
                end else if (m_score < 9999) m_score++;
            end
        end
        m_start_prev = START;
        m_fresh_prev = fresh;
    endtask

    task automatic check_all();
        chk("game_status", 32'(game_status), 32'(m_run));
        chk("collided", 32'(collided), 32'(m_over));
        chk("speed", 32'(speed), 32'(m_speed));
        chk("score", 32'(score), 32'(to_bcd(m_score)));
        chk("hi_score", 32'(hi_score), 32'(to_bcd(m_hi)));
        chk("pix_out", 32'(pix_out), 32'(m_pix));
    endtask

    task automatic step(input logic s, input logic f, input logic [8:0] r, input logic [9:0] c,
                        input logic cp, input logic dp);
        START = s; fresh = f; row_addr = r; col_addr = c; cactus_px = cp; dino_px = dp;
        @(posedge clkdiv);
        if (RESET) model_reset(); else model_step();
        #1 check_all();
    endtask

    // Random pixels/position, but never a visible overlap.
    task automatic rnd_step(input logic s, input logic f);
        logic [8:0] r;
        logic [9:0] c;
        logic       cp, dp;
        r  = 9'($urandom_range(0, 524));
        c  = 10'($urandom_range(0, 799));
        cp = 1'($urandom_range(0, 1));
        dp = 1'($urandom_range(0, 1));
        if (r < 480 && c < 640 && cp && dp) dp = 1'b0;
        step(s, f, r, c, cp, dp);
    endtask

    task automatic frame(input logic s);
        rnd_step(s, 1'b1);
        rnd_step(s, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (3) step(1'b0, 1'b1, 9'd0, 10'd0, 1'b0, 1'b0);
        RESET = 1'b0;
        rnd_step(1'b0, 1'b1);
        chk("reset_status", 32'(game_status), 32'd0);
        chk("reset_speed", 32'(speed), 32'd2);

        step(1'b1, 1'b1, 9'd10, 10'd10, 1'b0, 1'b0);
        chk("start_status", 32'(game_status), 32'd1);
        chk("start_score", 32'(score), 32'h0000);
        chk("start_speed", 32'(speed), 32'd2);
        START = 1'b0;

        repeat (60) frame(1'b0);
        chk("score60", 32'(score), 32'h0060);
        chk("run60", 32'(game_status), 32'd1);

        step(1'b0, 1'b1, 9'd350, 10'd100, 1'b1, 1'b1);
        step(1'b0, 1'b0, 9'd0, 10'd0, 1'b0, 1'b0);
        chk("over_collided", 32'(collided), 32'd1);
        chk("over_status", 32'(game_status), 32'd0);
        chk("over_hi", 32'(hi_score), 32'h0060);
        step(1'b0, 1'b0, 9'd5, 10'd5, 1'b0, 1'b0);
        chk("over_pix_inv", 32'(pix_out), 32'd1);
        repeat (4) frame(1'b0);
        chk("over_frozen", 32'(score), 32'h0060);

        step(1'b0, 1'b1, 9'd0, 10'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 9'd0, 10'd0, 1'b0, 1'b0);
        chk("restart_status", 32'(game_status), 32'd1);
        chk("restart_score", 32'(score), 32'h0000);
        chk("restart_collided", 32'(collided), 32'd0);
        frame(1'b1);
        chk("restart_hit_clear", 32'(score), 32'h0001);

        step(1'b0, 1'b1, 9'd350, 10'd700, 1'b1, 1'b1);
        step(1'b0, 1'b0, 9'd350, 10'd700, 1'b1, 1'b1);
        chk("invis_status", 32'(game_status), 32'd1);
        chk("invis_score", 32'(score), 32'h0002);

        repeat (44) frame(1'($urandom_range(0, 1)));
        chk("speed_clamp", 32'(speed), 32'd12);
        repeat (10000) frame(1'($urandom_range(0, 1)));
        chk("score_sat", 32'(score), 32'h9999);
        chk("speed_hold", 32'(speed), 32'd12);

        RESET = 1'b1;
        #2;
        model_reset();
        chk("areset_status", 32'(game_status), 32'd0);
        chk("areset_score", 32'(score), 32'h0000);
        chk("areset_hi", 32'(hi_score), 32'h0000);
        chk("areset_speed", 32'(speed), 32'd2);
        chk("areset_collided", 32'(collided), 32'd0);
        chk("areset_pix", 32'(pix_out), 32'd0);
        repeat (2) rnd_step(1'b0, 1'b1);
        RESET = 1'b0;
        repeat (3) rnd_step(1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
